// File: rtl/link_vc_tx_sched.sv
// Three-VC round-robin packet scheduler onto one 16-bit link transmit stream.
// Optional build macro LINK_TX_MAXLEN_CHECK_EN adds max-length truncation with a DRAIN state.
module link_vc_tx_sched #(
  parameter int MAX_WORDS = 20
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [2:0]  i_vc_valid,
  input  logic [2:0]  i_vc_sop,
  input  logic [2:0]  i_vc_eop,
  input  logic [47:0] i_vc_data,
  output logic [2:0]  o_vc_ready,
  input  logic        i_link_up,
  input  logic [2:0]  i_link_xoff,
  output logic        o_link_valid,
  output logic        o_link_sop,
  output logic        o_link_eop,
  output logic [15:0] o_link_data,
  output logic        o_busy,
  output logic [1:0]  o_cur_vc,
  output logic        o_proto_err
);

  if (MAX_WORDS < 2 || MAX_WORDS > 255) begin : g_bad_max_words
    $error("MAX_WORDS must be in 2..255");
  end

`ifdef LINK_TX_MAXLEN_CHECK_EN
  typedef enum logic [1:0] {IDLE = 2'd0, SEND = 2'd1, DRAIN = 2'd2} state_t;
  localparam logic [7:0] MAX_CNT = 8'(MAX_WORDS);
  logic [7:0] cnt_q, cnt_d;
`else
  typedef enum logic [1:0] {IDLE = 2'd0, SEND = 2'd1} state_t;
`endif

  state_t      state_q, state_d;
  logic [1:0]  ptr_q, ptr_d;
  logic [1:0]  cur_q, cur_d;
  logic        bubble_q, bubble_d;
  logic [2:0]  elig;
  logic        gnt_vld;
  logic [1:0]  gnt;
  logic [1:0]  scan_vc;
  logic        xfer, fwd_sop, fwd_eop, err;
  logic [15:0] fwd_data;

  function automatic logic [1:0] next_vc(input logic [1:0] v);
    return (v == 2'd2) ? 2'd0 : v + 2'd1;
  endfunction

  function automatic logic [15:0] vc_word(input logic [47:0] d, input logic [1:0] v);
    case (v)
      2'd0:    return d[15:0];
      2'd1:    return d[31:16];
      default: return d[47:32];
    endcase
  endfunction

  // xoff and link_up only matter here; a started packet ignores them.
  // bubble_q blocks the grant in the cycle right after any packet end.
  assign elig = i_vc_valid & i_vc_sop & ~i_link_xoff & {3{i_link_up & ~bubble_q}};

  always_comb begin
    gnt_vld = 1'b0;
    gnt     = 2'd0;
    scan_vc = ptr_q;
    for (int k = 0; k < 3; k++) begin
      if (!gnt_vld && elig[scan_vc]) begin
        gnt_vld = 1'b1;
        gnt     = scan_vc;
      end
      scan_vc = next_vc(scan_vc);
    end
  end

  // Handshake: a word moves on a VC exactly when i_vc_valid[v] & o_vc_ready[v].
  always_comb begin
    state_d    = state_q;
    ptr_d      = ptr_q;
    cur_d      = cur_q;
    bubble_d   = 1'b0;
    o_vc_ready = 3'b000;
    xfer       = 1'b0;
    fwd_sop    = 1'b0;
    fwd_eop    = 1'b0;
    fwd_data   = 16'h0000;
    err        = 1'b0;
`ifdef LINK_TX_MAXLEN_CHECK_EN
    cnt_d      = cnt_q;
`endif
    case (state_q)
      IDLE: begin
        // Stray non-sop words are swallowed so a broken source cannot stall.
        o_vc_ready = i_vc_valid & ~i_vc_sop;
        err        = |(i_vc_valid & ~i_vc_sop);
        if (gnt_vld) begin
          o_vc_ready[gnt] = 1'b1;
          xfer     = 1'b1;
          fwd_sop  = 1'b1;
          fwd_eop  = i_vc_eop[gnt];
          fwd_data = vc_word(i_vc_data, gnt);
          if (i_vc_eop[gnt]) begin
            ptr_d    = next_vc(gnt);
            bubble_d = 1'b1;
          end else begin
            state_d = SEND;
            cur_d   = gnt;
`ifdef LINK_TX_MAXLEN_CHECK_EN
            cnt_d   = 8'd1;
`endif
          end
        end
      end
      SEND: begin
        o_vc_ready[cur_q] = 1'b1;
        if (i_vc_valid[cur_q]) begin
          xfer     = 1'b1;
          fwd_eop  = i_vc_eop[cur_q];
          fwd_data = vc_word(i_vc_data, cur_q);
          err      = i_vc_sop[cur_q];
          if (i_vc_eop[cur_q]) begin
            state_d  = IDLE;
            ptr_d    = next_vc(cur_q);
            bubble_d = 1'b1;
          end
`ifdef LINK_TX_MAXLEN_CHECK_EN
          else if (cnt_q + 8'd1 == MAX_CNT) begin
            fwd_eop = 1'b1;
            err     = 1'b1;
            state_d = DRAIN;
          end
          cnt_d = cnt_q + 8'd1;
`endif
        end
      end
`ifdef LINK_TX_MAXLEN_CHECK_EN
      DRAIN: begin
        o_vc_ready[cur_q] = 1'b1;
        if (i_vc_valid[cur_q] && i_vc_eop[cur_q]) begin
          state_d  = IDLE;
          ptr_d    = next_vc(cur_q);
          bubble_d = 1'b1;
        end
      end
`endif
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      ptr_q        <= 2'd0;
      cur_q        <= 2'd0;
      bubble_q     <= 1'b0;
      o_link_valid <= 1'b0;
      o_link_sop   <= 1'b0;
      o_link_eop   <= 1'b0;
      o_link_data  <= 16'h0000;
      o_busy       <= 1'b0;
      o_cur_vc     <= 2'd3;
      o_proto_err  <= 1'b0;
    end else begin
      state_q      <= state_d;
      ptr_q        <= ptr_d;
      cur_q        <= cur_d;
      bubble_q     <= bubble_d;
      o_link_valid <= xfer;
      o_link_sop   <= fwd_sop;
      o_link_eop   <= fwd_eop;
      o_link_data  <= fwd_data;
      o_busy       <= (state_d != IDLE);
      o_cur_vc     <= (state_d != IDLE) ? cur_d : 2'd3;
      o_proto_err  <= err;
    end
  end

`ifdef LINK_TX_MAXLEN_CHECK_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt_q <= 8'd0;
    else        cnt_q <= cnt_d;
  end
`endif

endmodule

// File: tb/tb_link_vc_tx_sched.sv
// Bench for link_vc_tx_sched: directed scenarios pinned by literals plus
// randomized traffic checked every cycle against a packet-level reference model.
module tb_link_vc_tx_sched;

`ifdef LINK_TX_MAXLEN_CHECK_EN
  localparam int MAXW = 4;
`else
  localparam int MAXW = 20;
`endif

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [2:0]  vc_valid = '0, vc_sop = '0, vc_eop = '0;
  logic [47:0] vc_data = '0;
  logic [2:0]  vc_ready;
  logic        link_up = 1'b1;
  logic [2:0]  xoff = '0;
  logic        o_link_valid, o_link_sop, o_link_eop, o_busy, o_proto_err;
  logic [15:0] o_link_data;
  logic [1:0]  o_cur_vc;

  link_vc_tx_sched #(.MAX_WORDS(MAXW)) dut (
    .clk(clk), .rst_n(rst_n),
    .i_vc_valid(vc_valid), .i_vc_sop(vc_sop), .i_vc_eop(vc_eop), .i_vc_data(vc_data),
    .o_vc_ready(vc_ready), .i_link_up(link_up), .i_link_xoff(xoff),
    .o_link_valid(o_link_valid), .o_link_sop(o_link_sop), .o_link_eop(o_link_eop),
    .o_link_data(o_link_data), .o_busy(o_busy), .o_cur_vc(o_cur_vc), .o_proto_err(o_proto_err)
  );

  always #5 clk = ~clk;

  // ---------------- scoreboard state ----------------
  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  int err_cnt  = 0;
  logic [17:0] exp_q[$];
  typedef struct { int cyc; logic sop; logic eop; logic [15:0] data; logic [1:0] cur_vc; } log_t;
  log_t link_log[$];

  // reference model (packet-level view of the scheduler)
  bit   m_busy, m_drain, m_bubble;
  int   m_cur, m_ptr, m_cnt;
  logic exp_valid, exp_err, exp_busy;
  logic [1:0] exp_cur;
  logic [2:0] acc = '0;

  // ---------------- sources ----------------
  logic [17:0] src_q [3][$];
  int   valid_pct = 100;
  bit   rand_mode = 0;
  int   stall_cnt [3] = '{0, 0, 0};
  int   stall_at  [3] = '{0, 0, 0};
  bit   stall_arm [3] = '{0, 0, 0};

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s @cyc %0d: got %0h expected %0h", name, cyc, act, exp);
    end
  endtask

  task automatic model_reset();
    m_busy = 0; m_drain = 0; m_bubble = 0; m_cur = 0; m_ptr = 0; m_cnt = 0;
    exp_valid = 0; exp_err = 0; exp_busy = 0; exp_cur = 2'd3;
    exp_q.delete();
  endtask

  initial model_reset();

  // Single compare process: checks DUT against the model, then advances the model.
  always @(negedge clk) begin
    int g;
    bit e, nv, nerr, end_pkt;
    logic [2:0] er;
    logic [17:0] w;
    logic [15:0] d;
    cyc++;
    if (!rst_n) begin
      chk("rst_link_valid", o_link_valid, 0);
      chk("rst_link_sop", o_link_sop, 0);
      chk("rst_link_eop", o_link_eop, 0);
      chk("rst_link_data", o_link_data, 0);
      chk("rst_busy", o_busy, 0);
      chk("rst_cur_vc", o_cur_vc, 3);
      chk("rst_proto_err", o_proto_err, 0);
      model_reset();
      acc = '0;
    end else begin
      chk("link_valid", o_link_valid, exp_valid);
      if (exp_valid && exp_q.size() > 0) begin
        w = exp_q.pop_front();
        chk("link_word", {o_link_sop, o_link_eop, o_link_data}, w);
      end
      chk("busy", o_busy, exp_busy);
      chk("cur_vc", o_cur_vc, exp_cur);
      chk("proto_err", o_proto_err, exp_err);
      if (o_link_valid) link_log.push_back('{cyc, o_link_sop, o_link_eop, o_link_data, o_cur_vc});
      if (o_proto_err) err_cnt++;

      // which words must be accepted this cycle
      g = -1;
      er = '0;
      if (!m_busy) begin
        for (int k = 0; k < 3; k++) begin
          int v;
          v = (m_ptr + k) % 3;
          if (g < 0 && !m_bubble && vc_valid[v] && vc_sop[v] && !xoff[v] && link_up) g = v;
        end
        er = vc_valid & ~vc_sop;
        if (g >= 0) er[g] = 1'b1;
      end else begin
        er[m_cur] = 1'b1;
      end
      chk("vc_ready", vc_ready, er);
      acc = vc_valid & vc_ready;

      nv = 0; nerr = 0; end_pkt = 0;
      m_bubble = 0;
      if (!m_busy) begin
        nerr = |(vc_valid & ~vc_sop);
        if (g >= 0) begin
          d = vc_data[16*g +: 16];
          nv = 1;
          exp_q.push_back({1'b1, vc_eop[g], d});
          if (vc_eop[g]) begin
            m_ptr = (g + 1) % 3;
            m_bubble = 1;
          end else begin
            m_busy = 1; m_cur = g; m_cnt = 1; m_drain = 0;
          end
        end
      end else if (vc_valid[m_cur]) begin
        d = vc_data[16*m_cur +: 16];
        if (m_drain) begin
          end_pkt = vc_eop[m_cur];
        end else begin
          m_cnt++;
          e = vc_eop[m_cur];
          nerr = vc_sop[m_cur];
          end_pkt = e;
`ifdef LINK_TX_MAXLEN_CHECK_EN
          if (!e && m_cnt == MAXW) begin
            e = 1; nerr = 1; m_drain = 1;
          end
`endif
          nv = 1;
          exp_q.push_back({1'b0, e, d});
        end
        if (end_pkt) begin
          m_busy = 0; m_drain = 0;
          m_ptr = (m_cur + 1) % 3;
          m_bubble = 1;
        end
      end
      exp_valid = nv;
      exp_err   = nerr;
      exp_busy  = m_busy;
      exp_cur   = m_busy ? 2'(m_cur) : 2'd3;
    end
  end

  // ---------------- driver tasks ----------------
  task automatic drive_cycle();
    logic [17:0] w;
    @(posedge clk); #2;
    for (int v = 0; v < 3; v++)
      if (acc[v] && src_q[v].size() > 0) void'(src_q[v].pop_front());
    if (rand_mode) begin
      if ($urandom_range(9) == 0) xoff = 3'($urandom_range(7));
      link_up = ($urandom_range(19) != 0);
    end
    for (int v = 0; v < 3; v++) begin
      if (stall_arm[v] && src_q[v].size() == stall_at[v]) begin
        stall_cnt[v] = 3;
        stall_arm[v] = 0;
      end
      if (stall_cnt[v] > 0) begin
        stall_cnt[v]--;
        vc_valid[v] = 1'b0;
      end else if (src_q[v].size() > 0 && $urandom_range(99) < valid_pct) begin
        w = src_q[v][0];
        vc_valid[v] = 1'b1;
        vc_sop[v] = w[17];
        vc_eop[v] = w[16];
        vc_data[16*v +: 16] = w[15:0];
      end else begin
        vc_valid[v] = 1'b0;
        vc_sop[v] = 1'($urandom_range(1));
        vc_eop[v] = 1'($urandom_range(1));
        vc_data[16*v +: 16] = 16'($urandom_range(65535));
      end
    end
  endtask

  task automatic run_cycles(input int n);
    repeat (n) drive_cycle();
  endtask

  task automatic do_reset();
    @(posedge clk); #2;
    rst_n = 1'b0;
    for (int v = 0; v < 3; v++) src_q[v].delete();
    vc_valid = '0; vc_sop = '0; vc_eop = '0; vc_data = '0;
    xoff = '0; link_up = 1'b1;
    repeat (2) @(posedge clk);
    #2 rst_n = 1'b1;
    link_log.delete();
    err_cnt = 0;
  endtask

  task automatic wait_idle(input string name, input int max_cyc);
    bit done;
    done = 0;
    for (int i = 0; i < max_cyc && !done; i++) begin
      drive_cycle();
      done = (src_q[0].size() == 0 && src_q[1].size() == 0 && src_q[2].size() == 0 &&
              !m_busy && exp_q.size() == 0 && !exp_valid);
    end
    chk({"idle_within_bound_", name}, done, 1);
    run_cycles(2);
  endtask

  task automatic put_pkt(input int v, input logic [15:0] base, input int len);
    for (int w = 0; w < len; w++)
      src_q[v].push_back({(w == 0), (w == len - 1), 16'(base + 16'(w + 1))});
  endtask

  task automatic gen_pkt(input int v);
    int len;
    len = $urandom_range(6, 1);
    if ($urandom_range(9) == 0) src_q[v].push_back({2'b00, 16'($urandom_range(65535))});
    for (int w = 0; w < len; w++)
      src_q[v].push_back({(w == 0) || (w > 0 && $urandom_range(14) == 0), (w == len - 1),
                          16'($urandom_range(65535))});
  endtask

  // ---------------- test sequence ----------------
  initial begin
    logic [15:0] d;
    run_cycles(3);
    rst_n = 1'b1;
    run_cycles(2);

    // 1: single 4-word packet on VC1
    do_reset();
    put_pkt(1, 16'h1110, 4);
    wait_idle("t1", 50);
    chk("t1_len", link_log.size(), 4);
    if (link_log.size() == 4) begin
      chk("t1_first", {link_log[0].sop, link_log[0].eop, link_log[0].data}, {2'b10, 16'h1111});
      chk("t1_last", {link_log[3].sop, link_log[3].eop, link_log[3].data}, {2'b01, 16'h1114});
      chk("t1_consecutive", link_log[3].cyc - link_log[0].cyc, 3);
      chk("t1_cur_vc", link_log[0].cur_vc, 1);
    end
    chk("t1_no_err", err_cnt, 0);

    // 2: all VCs busy with 2-word packets -> 0,1,2,0,1,2 and one bubble
    do_reset();
    for (int p = 0; p < 2; p++)
      for (int v = 0; v < 3; v++) put_pkt(v, 16'(16'hD000 | (v << 8) | (p << 4)), 2);
    wait_idle("t2", 80);
    chk("t2_len", link_log.size(), 12);
    if (link_log.size() == 12) begin
      for (int i = 0; i < 6; i++) begin
        d = link_log[2*i].data;
        chk("t2_grant_order", d[11:8], i % 3);
        if (i < 5) chk("t2_gap", link_log[2*i+2].cyc - link_log[2*i].cyc, 3);
      end
    end

    // 3: VC0 xoff'd while VC0 and VC2 pending
    do_reset();
    xoff = 3'b001;
    put_pkt(0, 16'h0A00, 2);
    put_pkt(2, 16'h2A00, 2);
    run_cycles(8);
    chk("t3_served_first", link_log.size() > 0 ? link_log[0].data : 16'h0, 16'h2A01);
    chk("t3_vc0_held", src_q[0].size(), 2);
    xoff = 3'b000;
    wait_idle("t3", 40);
    chk("t3_vc0_next", link_log.size() == 4 ? {link_log[2].sop, link_log[2].data} : 17'h0,
        {1'b1, 16'h0A01});

    // 4: xoff/link_up dropped mid-packet
    do_reset();
    put_pkt(0, 16'h0B00, 6);
    for (int i = 0; i < 10 && src_q[0].size() > 5; i++) drive_cycle();
    xoff = 3'b111;
    link_up = 1'b0;
    wait_idle("t4", 40);
    chk("t4_len", link_log.size(), 6);
    if (link_log.size() == 6) begin
      chk("t4_eop6", {link_log[5].eop, link_log[5].data}, {1'b1, 16'h0B06});
      chk("t4_no_early_eop", link_log[4].eop, 0);
    end
    xoff = 3'b000;
    link_up = 1'b1;

    // 5: VC2 source gap of 3 cycles mid-packet
    do_reset();
    put_pkt(2, 16'h2C00, 5);
    stall_at[2] = 3;
    stall_arm[2] = 1;
    wait_idle("t5", 40);
    chk("t5_len", link_log.size(), 5);
    if (link_log.size() == 5) begin
      chk("t5_gap", link_log[2].cyc - link_log[1].cyc, 4);
      for (int i = 0; i < 5; i++) chk("t5_order", link_log[i].data, 16'h2C01 + 16'(i));
    end

`ifdef LINK_TX_MAXLEN_CHECK_EN
    // 6: 7-word packet truncated at MAX_WORDS = 4
    do_reset();
    put_pkt(0, 16'h0E00, 7);
    wait_idle("t6", 40);
    chk("t6_len", link_log.size(), 4);
    if (link_log.size() == 4) chk("t6_forced_eop", {link_log[3].eop, link_log[3].data}, {1'b1, 16'h0E04});
    chk("t6_err_once", err_cnt, 1);
`endif

    // 7: random traffic, abandoned by a reset mid-stream, then a full run
    do_reset();
    valid_pct = 70;
    rand_mode = 1;
    for (int v = 0; v < 3; v++) repeat (20) gen_pkt(v);
    run_cycles(200);
    do_reset();
    rand_mode = 1;
    for (int v = 0; v < 3; v++) repeat (40) gen_pkt(v);
    run_cycles(500);
    rand_mode = 0;
    xoff = 3'b000;
    link_up = 1'b1;
    wait_idle("rand", 3000);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation time limit reached at cyc %0d", cyc);
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/link_vc_tx_sched.md
Name: link_vc_tx_sched

Overview:
- Router-side transmit scheduler that drives the transmit side of one back-end link: valid/sop/eop/16-bit data plus per-VC xoff.
- Merges three virtual-channel packet sources into the single link stream with round-robin arbitration at packet boundaries.
- Honours the link's per-VC xoff and link-up status; one instance per link, four per GTP quad.

Parameters:
MAX_WORDS, 20, maximum words per packet including sop and eop words; used only when the optional feature is compiled in. Range 2..255.

Ports:
clk  in  1  link-side clock (back-end clock domain)
rst_n  in  1  asynchronous reset, active-low
i_vc_valid  in  3  per-VC word valid, bit v = VC v
i_vc_sop  in  3  per-VC start-of-packet marker
i_vc_eop  in  3  per-VC end-of-packet marker
i_vc_data  in  48  per-VC data; VC v on bits [16v+15:16v]
o_vc_ready  out  3  per-VC word accept; a word transfers when valid & ready
i_link_up  in  1  link status from the link layer
i_link_xoff  in  3  per-VC stop from the link layer (remote buffer full)
o_link_valid  out  1  word valid to link
o_link_sop  out  1  start of packet to link
o_link_eop  out  1  end of packet to link
o_link_data  out  16  data to link
o_busy  out  1  packet in progress
o_cur_vc  out  2  VC of the packet in progress; 3 when idle
o_proto_err  out  1  one-cycle pulse on source framing error

Behaviour:
- Reset (async assert, sync release): all o_link_* = 0, o_busy = 0, o_cur_vc = 3, o_proto_err = 0, state IDLE, RR pointer = VC0 highest priority.
- o_link_*, o_busy, o_cur_vc and o_proto_err are registered. o_vc_ready is combinational from state, grant and inputs.
- Latency: a word accepted in cycle N appears on o_link_* in cycle N+1 with o_link_valid = 1. o_link_valid = 0 in any cycle following a cycle with no transfer.
- FSM IDLE:
  - VC v is eligible when i_vc_valid[v] & i_vc_sop[v] & ~i_link_xoff[v] & i_link_up.
  - Grant goes to the first eligible VC starting at the RR pointer. o_vc_ready[grant] = 1 in the same cycle, and that sop word transfers.
  - If the granted word also has eop (single-word packet), stay in IDLE and advance the pointer to grant+1 mod 3. Otherwise go to SEND with cur = grant.
- VC v valid without sop while in IDLE: o_vc_ready[v] = 1, word dropped, o_proto_err pulses. If this coincides with a grant to another VC, the drop still happens.
- FSM SEND:
  - o_vc_ready[cur] = 1; all other ready bits = 0.
  - The accepted word is forwarded.
  - Word with eop: go to IDLE and set the pointer to cur+1 mod 3. One bubble cycle minimum between packets.
- Source valid low during SEND: no transfer, o_link_valid = 0 next cycle, remain in SEND. Gaps of any length are allowed.
- sop on a mid-packet word: the word is forwarded with o_link_sop = 0, and o_proto_err pulses.
- xoff or link_up changing mid-packet: no effect. Both are sampled only at grant; a started packet always completes.
- Simultaneous eligible VCs: the pointer decides, and every VC is served within 3 packets.
- o_busy = 1 from the cycle after the sop transfer until the cycle after the eop transfer. o_cur_vc follows the same timing.
- Reset mid-packet: output is abandoned immediately. No eop is generated; the link layer handles truncation.

Optional Feature:
LINK_TX_MAXLEN_CHECK_EN
- Defined: a word counter starts at 1 on the sop word.
  - When the count reaches MAX_WORDS and the word lacks eop, it is forwarded with o_link_eop forced to 1, and o_proto_err pulses.
  - FSM enters DRAIN: o_vc_ready[cur] = 1 and words are discarded (o_link_valid = 0) through the source eop, then IDLE with the pointer advanced.
- Not defined: no counter and no DRAIN state; packet length is unlimited.

Test Plan:
- Reset, then VC1 sends 4 words 0x1111..0x1114 (sop first, eop last) with xoff = 0 and link_up = 1 -> o_link_valid high for 4 consecutive cycles starting 1 cycle after the sop transfer, sop on 0x1111, eop on 0x1114, o_cur_vc = 1.
- All three VCs hold 2-word packets continuously -> grant order 0,1,2,0,1,2 with exactly one idle cycle between packets.
- i_link_xoff = 3'b001, VC0 and VC2 pending -> VC2 served, VC0 held with ready = 0. xoff deasserts -> VC0 served next.
- xoff[cur] asserted after the sop of a 6-word packet on VC0 -> all 6 words sent, eop on the 6th.
- VC2 deasserts valid for 3 cycles mid-packet -> o_link_valid low for 3 cycles, data order intact, o_busy stays 1.
- With LINK_TX_MAXLEN_CHECK_EN and MAX_WORDS = 4, VC0 sends 7 words -> 4 words out with eop on the 4th, o_proto_err pulses once, words 5..7 consumed with no output, then IDLE.
